// File: rtl/pixel_pkg.sv
// Shared types and helpers for the pixel raster tagging front-end.
package pixel_pkg;

    typedef logic [15:0] coord_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } raster_state_t;

    function automatic int pixel_width(input int fp_m, input int fp_n, input int fp_s);
        return fp_m + fp_n + fp_s;
    endfunction

endpackage

// File: rtl/pixel_raster_counter.sv
// Raster position counter: holds the coordinate the next in-frame pixel will receive.
module pixel_raster_counter
    import pixel_pkg::*;
#(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   restart,
    input  logic   advance,
    output coord_t row,
    output coord_t col,
    output logic   last
);

    localparam coord_t COL_LAST = coord_t'(WIDTH - 1);
    localparam coord_t ROW_LAST = coord_t'(HEIGHT - 1);

    // A restart consumes the SOF pixel as (0,0), so land on its successor.
    localparam coord_t RESTART_COL = (WIDTH == 1) ? coord_t'(0) : coord_t'(1);
    localparam coord_t RESTART_ROW = (WIDTH == 1 && HEIGHT > 1) ? coord_t'(1) : coord_t'(0);

    coord_t row_q;
    coord_t col_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else if (restart) begin
            row_q <= RESTART_ROW;
            col_q <= RESTART_COL;
        end else if (advance) begin
            if (col_q == COL_LAST) begin
                col_q <= '0;
                row_q <= (row_q == ROW_LAST) ? coord_t'(0) : row_q + 16'd1;
            end else begin
                col_q <= col_q + 16'd1;
            end
        end
    end

    assign row  = row_q;
    assign col  = col_q;
    assign last = (row_q == ROW_LAST) && (col_q == COL_LAST);

endmodule

// File: rtl/pixel_raster_tagger.sv
// Tags a raw pixel stream with raster coordinates and polices frame geometry.
module pixel_raster_tagger
    import pixel_pkg::*;
#(
    parameter int FP_M   = 8,
    parameter int FP_N   = 0,
    parameter int FP_S   = 0,
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    localparam int PW    = pixel_width(FP_M, FP_N, FP_S)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [PW-1:0] in_pixel,
    input  logic          in_valid,
    input  logic          in_sof,
    output logic [PW-1:0] out_pixel,
    output logic          out_valid,
    output logic [15:0]   out_row,
    output logic [15:0]   out_col,
    output logic          frame_done,
    output logic          err_short,
    output logic          err_orphan,
    output logic [15:0]   frame_count,
    output logic [15:0]   drop_count
);

    localparam bit SINGLE_PIXEL = (WIDTH == 1) && (HEIGHT == 1);

    raster_state_t state, state_next;

    coord_t cnt_row;
    coord_t cnt_col;
    logic   cnt_last;

    logic   restart;
    logic   advance;
    logic   emit;
    logic   done_c;
    logic   short_c;
    logic   orphan_c;
    coord_t tag_row;
    coord_t tag_col;

    logic [PW-1:0] pixel_p1;
    logic          vld_p1;
    coord_t        row_p1;
    coord_t        col_p1;
    logic          done_p1;
    logic          short_p1;
    logic          orphan_p1;
    logic [15:0]   frames_p1;
    logic [15:0]   drops_p1;

    pixel_raster_counter #(
        .WIDTH (WIDTH),
        .HEIGHT(HEIGHT)
    ) u_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .restart(restart),
        .advance(advance),
        .row    (cnt_row),
        .col    (cnt_col),
        .last   (cnt_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid && in_sof && !SINGLE_PIXEL) begin
                    state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                if (in_valid && !in_sof && cnt_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // SOF always tags (0,0) and restarts the counter, whatever the state.
    always_comb begin
        restart  = 1'b0;
        advance  = 1'b0;
        emit     = 1'b0;
        done_c   = 1'b0;
        short_c  = 1'b0;
        orphan_c = 1'b0;
        tag_row  = cnt_row;
        tag_col  = cnt_col;
        if (in_valid) begin
            case (state)
                IDLE: begin
                    if (in_sof) begin
                        emit    = 1'b1;
                        restart = 1'b1;
                        tag_row = '0;
                        tag_col = '0;
                        done_c  = SINGLE_PIXEL;
                    end else begin
                        orphan_c = 1'b1;
                    end
                end
                ACTIVE: begin
                    emit = 1'b1;
                    if (in_sof) begin
                        restart = 1'b1;
                        short_c = 1'b1;
                        tag_row = '0;
                        tag_col = '0;
                    end else begin
                        advance = 1'b1;
                        done_c  = cnt_last;
                    end
                end
                default: ;
            endcase
        end
    end

    // Stage p1: registered outputs, data held between valid beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_p1  <= '0;
            vld_p1    <= 1'b0;
            row_p1    <= '0;
            col_p1    <= '0;
            done_p1   <= 1'b0;
            short_p1  <= 1'b0;
            orphan_p1 <= 1'b0;
            frames_p1 <= '0;
            drops_p1  <= '0;
        end else begin
            vld_p1    <= emit;
            done_p1   <= done_c;
            short_p1  <= short_c;
            orphan_p1 <= orphan_c;
            if (emit) begin
                pixel_p1 <= in_pixel;
                row_p1   <= tag_row;
                col_p1   <= tag_col;
            end
            if (done_c) begin
                frames_p1 <= frames_p1 + 16'd1;
            end
            if (orphan_c && drops_p1 != 16'hFFFF) begin
                drops_p1 <= drops_p1 + 16'd1;
            end
        end
    end

    assign out_pixel   = pixel_p1;
    assign out_valid   = vld_p1;
    assign out_row     = row_p1;
    assign out_col     = col_p1;
    assign frame_done  = done_p1;
    assign err_short   = short_p1;
    assign err_orphan  = orphan_p1;
    assign frame_count = frames_p1;
    assign drop_count  = drops_p1;

endmodule

// File: tb/tb_pixel_raster_tagger.sv
// Directed bench for pixel_raster_tagger: a 4x2 instance and a 1x1 instance on shared inputs.
module tb_pixel_raster_tagger;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_pixel;
    logic        in_valid;
    logic        in_sof;

    logic [7:0]  a_pixel;
    logic        a_valid;
    logic [15:0] a_row;
    logic [15:0] a_col;
    logic        a_done;
    logic        a_short;
    logic        a_orphan;
    logic [15:0] a_frames;
    logic [15:0] a_drops;

    logic [7:0]  b_pixel;
    logic        b_valid;
    logic [15:0] b_row;
    logic [15:0] b_col;
    logic        b_done;
    logic        b_short;
    logic        b_orphan;
    logic [15:0] b_frames;
    logic [15:0] b_drops;

    int n_checks;
    int n_fail;

    pixel_raster_tagger #(.WIDTH(4), .HEIGHT(2)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_pixel(in_pixel), .in_valid(in_valid), .in_sof(in_sof),
        .out_pixel(a_pixel), .out_valid(a_valid), .out_row(a_row), .out_col(a_col),
        .frame_done(a_done), .err_short(a_short), .err_orphan(a_orphan),
        .frame_count(a_frames), .drop_count(a_drops)
    );

    pixel_raster_tagger #(.WIDTH(1), .HEIGHT(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_pixel(in_pixel), .in_valid(in_valid), .in_sof(in_sof),
        .out_pixel(b_pixel), .out_valid(b_valid), .out_row(b_row), .out_col(b_col),
        .frame_done(b_done), .err_short(b_short), .err_orphan(b_orphan),
        .frame_count(b_frames), .drop_count(b_drops)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [7:0] p, input logic v, input logic s);
        in_pixel = p;
        in_valid = v;
        in_sof   = s;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_pixel = '0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [92:0] obs;
        rst_n    = 1'b0;
        in_pixel = '0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        #2;
        @(posedge clk);
        #1;
        obs = {a_pixel, a_valid, a_row, a_col, a_done, a_short, a_orphan, a_frames, a_drops};
        n_checks++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL reset_a: got %h expected 0", obs);
        end
        obs = {b_pixel, b_valid, b_row, b_col, b_done, b_short, b_orphan, b_frames, b_drops};
        n_checks++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL reset_b: got %h expected 0", obs);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [15:0] er, ec;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(8'h10 + 8'(i), 1'b1, i == 0);
            er = 16'(i / 4);
            ec = 16'(i % 4);
            n_checks++;
            if (a_valid !== 1'b1 || a_pixel !== 8'h10 + 8'(i) || a_row !== er || a_col !== ec) begin
                n_fail++;
                $display("FAIL b2b_tag[%0d]: got v=%b p=%h r=%0d c=%0d expected v=1 p=%h r=%0d c=%0d",
                         i, a_valid, a_pixel, a_row, a_col, 8'h10 + 8'(i), er, ec);
            end
            n_checks++;
            if (a_done !== (i == 7) || a_short !== 1'b0 || a_orphan !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_pulse[%0d]: got done=%b short=%b orphan=%b expected done=%b short=0 orphan=0",
                         i, a_done, a_short, a_orphan, (i == 7));
            end
        end
        drive(8'h99, 1'b0, 1'b0);
        n_checks++;
        if (a_valid !== 1'b0 || a_done !== 1'b0 || a_frames !== 16'd1 || a_pixel !== 8'h17
            || a_row !== 16'd1 || a_col !== 16'd3) begin
            n_fail++;
            $display("FAIL b2b_after: got v=%b done=%b frames=%0d p=%h r=%0d c=%0d expected v=0 done=0 frames=1 p=17 r=1 c=3",
                     a_valid, a_done, a_frames, a_pixel, a_row, a_col);
        end
    endtask

    task automatic test_bubbles();
        int k;
        logic [15:0] er, ec;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            k = i / 2;
            // Gap cycles also carry a stray SOF, which must be ignored without valid.
            if (i % 2 == 0) drive(8'h10 + 8'(k), 1'b1, i == 0);
            else            drive(8'hEE, 1'b0, 1'b1);
            er = 16'(k / 4);
            ec = 16'(k % 4);
            n_checks++;
            if (a_valid !== (i % 2 == 0) || a_pixel !== 8'h10 + 8'(k) || a_row !== er || a_col !== ec) begin
                n_fail++;
                $display("FAIL bubble_tag[%0d]: got v=%b p=%h r=%0d c=%0d expected v=%b p=%h r=%0d c=%0d",
                         i, a_valid, a_pixel, a_row, a_col, (i % 2 == 0), 8'h10 + 8'(k), er, ec);
            end
            n_checks++;
            if (a_done !== (i == 14) || a_short !== 1'b0) begin
                n_fail++;
                $display("FAIL bubble_pulse[%0d]: got done=%b short=%b expected done=%b short=0",
                         i, a_done, a_short, (i == 14));
            end
        end
        n_checks++;
        if (a_frames !== 16'd1) begin
            n_fail++;
            $display("FAIL bubble_frames: got %0d expected 1", a_frames);
        end
    endtask

    task automatic test_orphan();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(8'h50 + 8'(i), 1'b1, 1'b0);
            n_checks++;
            if (a_valid !== 1'b0 || a_orphan !== 1'b1 || a_drops !== 16'(i + 1)) begin
                n_fail++;
                $display("FAIL orphan[%0d]: got v=%b orphan=%b drops=%0d expected v=0 orphan=1 drops=%0d",
                         i, a_valid, a_orphan, a_drops, i + 1);
            end
        end
        for (int i = 0; i < 8; i++) begin
            drive(8'h20 + 8'(i), 1'b1, i == 0);
            n_checks++;
            if (a_valid !== 1'b1 || a_row !== 16'(i / 4) || a_col !== 16'(i % 4)
                || a_orphan !== 1'b0 || a_done !== (i == 7)) begin
                n_fail++;
                $display("FAIL orphan_frame[%0d]: got v=%b r=%0d c=%0d orphan=%b done=%b expected v=1 r=%0d c=%0d orphan=0 done=%b",
                         i, a_valid, a_row, a_col, a_orphan, a_done, i / 4, i % 4, (i == 7));
            end
        end
        drive(8'h00, 1'b0, 1'b0);
        n_checks++;
        if (a_drops !== 16'd3 || a_frames !== 16'd1) begin
            n_fail++;
            $display("FAIL orphan_counts: got drops=%0d frames=%0d expected drops=3 frames=1", a_drops, a_frames);
        end
    endtask

    task automatic test_short_frame();
        int k;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(8'h30 + 8'(i), 1'b1, i == 0);
            n_checks++;
            if (a_short !== 1'b0 || a_row !== 16'(i / 4) || a_col !== 16'(i % 4)) begin
                n_fail++;
                $display("FAIL short_pre[%0d]: got short=%b r=%0d c=%0d expected short=0 r=%0d c=%0d",
                         i, a_short, a_row, a_col, i / 4, i % 4);
            end
        end
        drive(8'hAA, 1'b1, 1'b1);
        n_checks++;
        if (a_short !== 1'b1 || a_valid !== 1'b1 || a_pixel !== 8'hAA || a_row !== 16'd0
            || a_col !== 16'd0 || a_done !== 1'b0) begin
            n_fail++;
            $display("FAIL short_sof: got short=%b v=%b p=%h r=%0d c=%0d done=%b expected short=1 v=1 p=aa r=0 c=0 done=0",
                     a_short, a_valid, a_pixel, a_row, a_col, a_done);
        end
        for (int i = 0; i < 7; i++) begin
            k = i + 1;
            drive(8'h40 + 8'(i), 1'b1, 1'b0);
            n_checks++;
            if (a_valid !== 1'b1 || a_row !== 16'(k / 4) || a_col !== 16'(k % 4)
                || a_short !== 1'b0 || a_done !== (i == 6)) begin
                n_fail++;
                $display("FAIL short_rest[%0d]: got v=%b r=%0d c=%0d short=%b done=%b expected v=1 r=%0d c=%0d short=0 done=%b",
                         i, a_valid, a_row, a_col, a_short, a_done, k / 4, k % 4, (i == 6));
            end
        end
        drive(8'h00, 1'b0, 1'b0);
        n_checks++;
        if (a_frames !== 16'd1) begin
            n_fail++;
            $display("FAIL short_frames: got %0d expected 1", a_frames);
        end
    endtask

    task automatic test_async_reset();
        logic [92:0] obs;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(8'h60 + 8'(i), 1'b1, i == 0);
        end
        n_checks++;
        if (a_valid !== 1'b1 || a_col !== 16'd2) begin
            n_fail++;
            $display("FAIL arst_pre: got v=%b c=%0d expected v=1 c=2", a_valid, a_col);
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        obs = {a_pixel, a_valid, a_row, a_col, a_done, a_short, a_orphan, a_frames, a_drops};
        n_checks++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL arst_now: got %h expected 0", obs);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(8'h77, 1'b1, 1'b0);
        n_checks++;
        if (a_valid !== 1'b0 || a_orphan !== 1'b1 || a_drops !== 16'd1 || a_done !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_orphan: got v=%b orphan=%b drops=%0d done=%b expected v=0 orphan=1 drops=1 done=0",
                     a_valid, a_orphan, a_drops, a_done);
        end
    endtask

    task automatic test_single_pixel();
        do_reset();
        drive(8'h33, 1'b1, 1'b1);
        n_checks++;
        if (b_valid !== 1'b1 || b_pixel !== 8'h33 || b_row !== 16'd0 || b_col !== 16'd0
            || b_done !== 1'b1 || b_short !== 1'b0 || b_frames !== 16'd1) begin
            n_fail++;
            $display("FAIL single_1: got v=%b p=%h r=%0d c=%0d done=%b short=%b frames=%0d expected v=1 p=33 r=0 c=0 done=1 short=0 frames=1",
                     b_valid, b_pixel, b_row, b_col, b_done, b_short, b_frames);
        end
        drive(8'h44, 1'b1, 1'b1);
        n_checks++;
        if (b_valid !== 1'b1 || b_pixel !== 8'h44 || b_row !== 16'd0 || b_col !== 16'd0
            || b_done !== 1'b1 || b_short !== 1'b0 || b_frames !== 16'd2) begin
            n_fail++;
            $display("FAIL single_2: got v=%b p=%h r=%0d c=%0d done=%b short=%b frames=%0d expected v=1 p=44 r=0 c=0 done=1 short=0 frames=2",
                     b_valid, b_pixel, b_row, b_col, b_done, b_short, b_frames);
        end
        drive(8'h00, 1'b0, 1'b0);
        n_checks++;
        if (b_valid !== 1'b0 || b_done !== 1'b0 || b_frames !== 16'd2 || b_orphan !== 1'b0) begin
            n_fail++;
            $display("FAIL single_after: got v=%b done=%b frames=%0d orphan=%b expected v=0 done=0 frames=2 orphan=0",
                     b_valid, b_done, b_frames, b_orphan);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_back_to_back();
        test_bubbles();
        test_orphan();
        test_short_frame();
        test_async_reset();
        test_single_pixel();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_raster_tagger.md
Name: pixel_raster_tagger

Overview:
- Front-end stage that feeds every downstream pixel_data_interface consumer.
- Accepts a raw sensor/DMA pixel stream (pixel, valid, start-of-frame), attaches raster coordinates, and drives row, col, pixel and valid for the next stage.
- Enforces frame geometry: detects short frames and orphan pixels, emits a frame-done pulse, and counts frames.

Parameters:
- FP_M, 8, integer bits of pixel fixed-point format
- FP_N, 0, fractional bits of pixel format
- FP_S, 0, sign bits (0 or 1); pixel width PW = FP_M+FP_N+FP_S
- WIDTH, 640, pixels per row; legal range 1..65535
- HEIGHT, 480, rows per frame; legal range 1..65535

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- in_pixel  in  PW  raw pixel
- in_valid  in  1  in_pixel is valid this cycle
- in_sof  in  1  qualifies in_valid: this pixel is the first of a frame
- out_pixel  out  PW  tagged pixel (pixel_data_interface pixel)
- out_valid  out  1  pixel_data_interface valid
- out_row  out  16  row coordinate
- out_col  out  16  column coordinate
- frame_done  out  1  one-cycle pulse, coincident with out_valid of last pixel (HEIGHT-1, WIDTH-1)
- err_short  out  1  one-cycle pulse: SOF arrived mid-frame
- err_orphan  out  1  one-cycle pulse: pixel dropped while IDLE (no SOF)
- frame_count  out  16  completed frames, wraps at 2^16
- drop_count  out  16  dropped orphan pixels, saturates at 16'hFFFF

Behaviour:
- Reset (async assert, sync deassert handled upstream): all outputs 0; state IDLE; internal col/row counters 0. Reset mid-frame discards the partial frame with no pulses.
- Latency: exactly 1 cycle, in_valid to out_valid; all outputs registered.
- out_pixel/out_row/out_col update only on cycles where out_valid=1, else hold last value.
- in_sof without in_valid is ignored in every state.
- State IDLE:
  - in_valid&in_sof: emit (0,0) and go to ACTIVE, with next col=1 (or next row=1 if WIDTH=1). If WIDTH=HEIGHT=1, also pulse frame_done, increment frame_count, and stay IDLE.
  - in_valid&!in_sof: no out_valid; pulse err_orphan; drop_count++ (saturating).
- State ACTIVE, in_valid&!in_sof: emit current (row,col).
  - If col==WIDTH-1: col to 0, row++.
  - If (row,col)==(HEIGHT-1,WIDTH-1): pulse frame_done, frame_count++, go to IDLE.
- State ACTIVE, in_valid&in_sof: pulse err_short; emit pixel as (0,0); restart counters as in IDLE; stay ACTIVE. No frame_done and no frame_count change.
- in_valid gaps (bubbles) inside a frame are legal, and counters hold across them.
- Counter comparisons use 16-bit unsigned; WIDTH-1/HEIGHT-1 are computed as constants.
- Pulses (frame_done, err_short, err_orphan) are at most one per cycle and are never asserted simultaneously with each other.

Decomposition:
- Package pixel_pkg:
  - typedef coord_t (logic [15:0])
  - enum raster_state_t {IDLE, ACTIVE}
  - function pixel_width(FP_M,FP_N,FP_S)
- Sub-module pixel_raster_counter:
  - Inputs: clk, rst_n, restart, advance.
  - Outputs: row, col, last (at final coordinate).
  - Parameters: WIDTH, HEIGHT.
  - The tagger FSM instantiates one.

Test Plan (WIDTH=4, HEIGHT=2 unless noted):
- SOF + 8 back-to-back pixels 0x10..0x17 -> out (r,c) (0,0)..(0,3),(1,0)..(1,3) one cycle later; frame_done with 0x17; frame_count=1.
- Same frame with in_valid toggling 1,0,1,0 -> identical coordinates on valid cycles only; outputs held during gaps; frame_done on 8th valid.
- 3 pixels without SOF in IDLE -> no out_valid; err_orphan 3 pulses; drop_count=3; following SOF frame tags from (0,0).
- SOF, 5 pixels, then SOF pixel 0xAA -> err_short pulse; 0xAA tagged (0,0); 7 more pixels complete the frame with frame_done; frame_count=1.
- rst_n low asynchronously after 3 pixels -> outputs 0 immediately; after release, pixel without SOF is orphaned (drop_count=1).
- WIDTH=1, HEIGHT=1: two SOF pixels -> each tagged (0,0) with frame_done; frame_count=2; no err_short.
